// File: rtl/eq_comparator_32b.sv
// rtl/eq_comparator_32b.sv - 32-bit equality comparator with registered tap and saturating match counter
//
// Purpose:
//   Combinational 32-bit equality compare for branch resolution, built as
//   per-bit XNOR -> per-byte AND -> 4-input AND. Beside it, a small clocked
//   block registers the compare result and counts matching cycles. The count
//   saturates at all-ones and never wraps.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous reset, active low
//   in0          in  32   first operand
//   in1          in  32   second operand
//   eq           out  1   combinational, 1 iff in0 == in1
//   eq_byte      out  4   combinational per-byte equality, bit k covers bits [8k+7:8k]
//   eq_q         out  1   eq registered on the rising edge of clk
//   match_count  out 32   saturating count of rising edges where eq was 1

`timescale 1ns/1ps

module eq_comparator_32b (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        eq,
  output logic [3:0]  eq_byte,
  output logic        eq_q,
  output logic [31:0] match_count
);

  logic [31:0] bit_eq;
  logic        eq_reg_q;
  logic [31:0] match_count_q;
  logic [31:0] match_count_d;

  // Per-bit equality. Clock and reset play no part in this path, so the
  // compare stays valid while reset is held.
  assign bit_eq = ~(in0 ^ in1);

  always_comb begin
    eq_byte = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      eq_byte[k] = &bit_eq[8*k +: 8];
    end
  end

  // The full compare is derived from the byte results, not from a separate
  // 32-bit reduction, so eq always equals the AND of eq_byte by construction.
  assign eq = &eq_byte;

  // Saturate: once all ones, hold instead of wrapping back to zero.
  always_comb begin
    match_count_d = match_count_q;
    if (eq && (match_count_q != 32'hFFFF_FFFF)) begin
      match_count_d = match_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eq_reg_q      <= 1'b0;
      match_count_q <= 32'd0;
    end else begin
      eq_reg_q      <= eq;
      match_count_q <= match_count_d;
    end
  end

  assign eq_q        = eq_reg_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_eq_comparator_32b.sv
// tb/tb_eq_comparator_32b.sv - directed self-checking bench for eq_comparator_32b

`timescale 1ns/1ps

module tb_eq_comparator_32b;

  logic        clk;
  logic        reset;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        eq;
  logic [3:0]  eq_byte;
  logic        eq_q;
  logic [31:0] match_count;

  int n_checks = 0;
  int n_pass   = 0;

  eq_comparator_32b dut (
    .clk         (clk),
    .reset       (reset),
    .in0         (in0),
    .in1         (in1),
    .eq          (eq),
    .eq_byte     (eq_byte),
    .eq_q        (eq_q),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Apply a pair, let it settle, and check eq, eq_byte and their consistency.
  task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_eq, input logic [3:0] exp_byte);
    in0 = a;
    in1 = b;
    #1;
    check({tag, ".eq"}, {31'd0, eq}, {31'd0, exp_eq});
    check({tag, ".eq_byte"}, {28'd0, eq_byte}, {28'd0, exp_byte});
    check({tag, ".and"}, {31'd0, eq}, {31'd0, &eq_byte});
  endtask

  // Drive 1 unit after a rising edge; return 8 units later, before the next edge.
  task automatic drive_cycle(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    in0 = a;
    in1 = b;
    #8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_b;
    logic [31:0] r;

    reset = 1'b0;
    in0   = 32'd0;
    in1   = 32'd0;
    #2;
    check("reset.eq_q", {31'd0, eq_q}, 32'd0);
    check("reset.match_count", match_count, 32'd0);

    // Combinational checks run while reset is held low.
    comb_vec("basic00", 32'd0, 32'd0, 1'b1, 4'b1111);
    comb_vec("basic01", 32'd0, 32'd1, 1'b0, 4'b1110);
    comb_vec("basic10", 32'd1, 32'd0, 1'b0, 4'b1110);
    comb_vec("basic11", 32'd1, 32'd1, 1'b1, 4'b1111);

    comb_vec("eq2",    32'd2,    32'd2,    1'b1, 4'b1111);
    comb_vec("eq15",   32'd15,   32'd15,   1'b1, 4'b1111);
    comb_vec("eq100",  32'd100,  32'd100,  1'b1, 4'b1111);
    comb_vec("eq255",  32'd255,  32'd255,  1'b1, 4'b1111);
    comb_vec("eq1023", 32'd1023, 32'd1023, 1'b1, 4'b1111);
    comb_vec("ne0_2",      32'd0,    32'd2,    1'b0, 4'b1110);
    comb_vec("ne3_2",      32'd3,    32'd2,    1'b0, 4'b1110);
    comb_vec("ne15_14",    32'd15,   32'd14,   1'b0, 4'b1110);
    comb_vec("ne100_99",   32'd100,  32'd99,   1'b0, 4'b1110);
    comb_vec("ne256_255",  32'd256,  32'd255,  1'b0, 4'b1100);
    comb_vec("ne1024_1023", 32'd1024, 32'd1023, 1'b0, 4'b1100);
    comb_vec("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b1111);
    comb_vec("signless", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 4'b0111);

    for (int k = 0; k < 32; k++) begin
      b = 32'd1 << k;
      exp_b = 4'b1111 & ~(4'b0001 << (k / 8));
      comb_vec($sformatf("bit%0d", k), 32'd0, b, 1'b0, exp_b);
    end

    r = $urandom(32'd20240611);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? a : $urandom;
      // Occasionally differ in only one byte to exercise partial matches.
      if (i % 4 == 1) b = a ^ (32'h0000_0055 << (8 * (i % 3)));
      for (int k = 0; k < 4; k++) exp_b[k] = (a[8*k +: 8] == b[8*k +: 8]);
      comb_vec($sformatf("rand%0d", i), a, b, (a == b), exp_b);
    end

    // Clock has been running the whole time; reset must have held the taps at 0.
    check("reset_hold.eq_q", {31'd0, eq_q}, 32'd0);
    check("reset_hold.match_count", match_count, 32'd0);

    // Registered path: equal, unequal, equal, then one more to observe the last capture.
    @(posedge clk);
    #1;
    reset = 1'b1;
    in0 = 32'h1234_5678;
    in1 = 32'h1234_5678;
    #8;
    check("reg0.eq_q", {31'd0, eq_q}, 32'd0);
    check("reg0.match_count", match_count, 32'd0);
    drive_cycle(32'h0000_0007, 32'h0000_0008);
    check("reg1.eq_q", {31'd0, eq_q}, 32'd1);
    check("reg1.match_count", match_count, 32'd1);
    drive_cycle(32'hCAFE_F00D, 32'hCAFE_F00D);
    check("reg2.eq_q", {31'd0, eq_q}, 32'd0);
    check("reg2.match_count", match_count, 32'd1);
    drive_cycle(32'd1, 32'd2);
    check("reg3.eq_q", {31'd0, eq_q}, 32'd1);
    check("reg3.match_count", match_count, 32'd2);

    // Mid-operation async reset, between edges.
    reset = 1'b0;
    #0.5;
    check("midreset.eq_q", {31'd0, eq_q}, 32'd0);
    check("midreset.match_count", match_count, 32'd0);

    // Saturation: preload just below all-ones, then count up and hold.
    @(posedge clk);
    #1;
    reset = 1'b1;
    in0 = 32'hA5A5_A5A5;
    in1 = 32'hA5A5_A5A5;
    #2;
    force dut.match_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.match_count_q;
    #5;
    check("preload.match_count", match_count, 32'hFFFF_FFFE);
    drive_cycle(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    check("sat.match_count", match_count, 32'hFFFF_FFFF);
    check("sat.eq_q", {31'd0, eq_q}, 32'd1);
    drive_cycle(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    check("sat_hold.match_count", match_count, 32'hFFFF_FFFF);

    reset = 1'b0;
    #0.5;
    check("satreset.match_count", match_count, 32'd0);
    check("satreset.eq_q", {31'd0, eq_q}, 32'd0);
    @(posedge clk);
    #1;
    check("satreset_hold.match_count", match_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_comparator_32b.md
# eq_comparator_32b

32-bit equality comparator for the TinyRV1 datapath, used for branch resolution (`bne`-style compares) and general operand-equality checks. The core output `eq` is purely combinational and asserts when both 32-bit operands are bit-for-bit identical. A small clocked side block registers the compare result and keeps a saturating count of matching cycles for debug and observability. The datapath uses only `eq`; the registered outputs are optional taps.

## Interface

Parameters: none. Width is fixed at 32 bits.

Ports:
- `clk`  input  1  system clock; rising edge is active.
- `reset`  input  1  reset, asynchronous and active-low (0 = reset asserted).
- `in0`  input  32  first operand.
- `in1`  input  32  second operand.
- `eq`  output  1  combinational: 1 iff `in0 == in1` across all 32 bits.
- `eq_byte`  output  4  combinational per-byte equality; bit k = (`in0[8k+7:8k] == in1[8k+7:8k]`).
- `eq_q`  output  1  `eq` registered on the rising edge of `clk`.
- `match_count`  output  32  saturating count of rising edges at which `eq` was 1.

## Operation

- Compare is unsigned and bitwise, with no sign interpretation.
  - Example: 0xFFFFFFFF vs 0x7FFFFFFF gives `eq`=0.
- Structure: 32 XNOR bits feed four 8-input AND reductions (`eq_byte`), which feed a 4-input AND (`eq`).
- `eq` must equal the AND of all four `eq_byte` bits at all times.
- Outputs `eq` and `eq_byte` have no dependence on `clk` or `reset`. They are valid during reset.
- On each rising `clk` with `reset`=1:
  - `eq_q` takes the current `eq`.
  - If `eq`=1 and `match_count` != 0xFFFFFFFF, `match_count` increments by 1.
  - If `match_count` = 0xFFFFFFFF, it holds. It saturates and never wraps to 0.
- X/Z on the inputs is not handled specially. Only 2-state behaviour is specified.

## Timing

- `eq` and `eq_byte`: zero-cycle latency, combinational from `in0`/`in1`.
  - Must settle well within one clock period.
  - The bench drives inputs 1 time unit after an edge and samples 8 units later.
- `eq_q`: one-cycle latency relative to `eq`.
- `match_count`: updates one cycle after the matching cycle.
- Reset:
  - Asserting `reset`=0 immediately, with no clock, forces `eq_q`=0 and `match_count`=0.
  - Both hold at 0 while `reset`=0.
  - The first rising edge after deassertion samples normally.
- Reset mid-operation: counter and register clear regardless of state, including when saturated.
- Simultaneous events:
  - `reset` low at a rising edge means reset wins.
  - `in0`/`in1` changing near an edge: `eq_q` captures whatever `eq` is settled at that edge. Standard setup applies.

## Test plan

- Basic:
  - (0,0) -> `eq`=1.
  - (0,1) -> 0.
  - (1,0) -> 0.
  - (1,1) -> 1.
  - `eq_byte`=4'b1111 only on the equal pairs.
- Directed near-miss:
  - Equal pairs (2,2), (15,15), (100,100), (255,255), (1023,1023) -> `eq`=1.
  - Unequal pairs (0,2), (3,2), (15,14), (100,99), (256,255), (1024,1023) -> `eq`=0.
  - For (256,255): `eq_byte`=4'b1100.
- Single-bit and byte locality:
  - in0=0, in1=1<<k for each k in 0..31 -> `eq`=0, and only `eq_byte[k/8]`=0.
  - (0xFFFFFFFF,0xFFFFFFFF) -> `eq`=1.
- Random: 10+ seeded random pairs plus forced-equal pairs -> `eq` == (`in0`==`in1`) every check.
- Registered path:
  - Apply reset low -> `eq_q`=0 and `match_count`=0 immediately, with no clock.
  - Release reset, then drive equal, unequal, equal over 3 cycles.
  - Result: `eq_q` follows `eq` by one cycle and `match_count`=2.
- Saturation and async reset:
  - Hold equal inputs until `match_count` reaches 0xFFFFFFFF (preload via force in simulation).
  - One more edge -> `match_count` stays 0xFFFFFFFF.
  - Pulse `reset` low between edges -> `match_count` reads 0 before the next edge.
